// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: response-owner state,
// default bus widths and the memory command record.
package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 7;
   localparam int unsigned DATA_W_DEF = 32;

   // Which requester owns the read data returning this cycle.
   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU_RD,
      OWN_DMA_RD
   } owner_e;

   // One memory access: used for each requester's payload and the muxed command.
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: CPU and DMA req/gnt channels
// plus the single-port memory connection.
// slave  = arbiter side, master = requesters/memory side.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 32
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_stall;

   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_gnt, dma_rvalid, dma_rdata,
      output mem_address, mem_write_data, mem_write, mem_read,
      input  mem_read_data
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_gnt, dma_rvalid, dma_rdata,
      input  mem_address, mem_write_data, mem_write, mem_read,
      output mem_read_data
   );

endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data_mem between the CPU
// load/store path and the DMA/debug loader. CPU has priority, except that
// DMA takes one grant after DMA_MAX_WAIT consecutive denied cycles.
// Read data comes back one cycle after the grant, steered by an owner FSM.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned DMA_MAX_WAIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam logic [3:0] MAX_WAIT = 4'(DMA_MAX_WAIT);

   mem_req_t          cpu_cmd;
   mem_req_t          dma_cmd;
   mem_req_t          win_cmd;
   logic              cpu_gnt;
   logic              dma_gnt;
   logic              any_gnt;
   logic              dma_prio;
   logic [3:0]        wait_cnt;
   owner_e            owner_q;
   owner_e            owner_d;
   logic              cpu_rvalid;
   logic              dma_rvalid;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] rd_data;

   assign cpu_cmd  = '{we: bus.cpu_we, addr: bus.cpu_addr, wdata: bus.cpu_wdata};
   assign dma_cmd  = '{we: bus.dma_we, addr: bus.dma_addr, wdata: bus.dma_wdata};
   assign dma_prio = (wait_cnt == MAX_WAIT);

   // Pick at most one winner; nothing is granted while reset is held.
   always_comb begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
      if (!reset) begin
         if (bus.dma_req && (dma_prio || !bus.cpu_req)) begin
            dma_gnt = 1'b1;
         end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
         end
      end
   end

   // Steer the winner's payload onto the memory; idle bus is all zeros.
   always_comb begin
      win_cmd = '0;
      if (cpu_gnt) begin
         win_cmd = cpu_cmd;
      end else if (dma_gnt) begin
         win_cmd = dma_cmd;
      end
   end

   assign any_gnt            = cpu_gnt | dma_gnt;
   assign win_addr           = win_cmd.addr;
   assign bus.mem_address    = win_addr;
   assign bus.mem_write_data = win_cmd.wdata;
   assign bus.mem_write      = any_gnt & win_cmd.we;
   assign bus.mem_read       = any_gnt & ~win_cmd.we;

   // Count consecutive denied DMA cycles, saturating at the priority threshold.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!bus.dma_req || dma_gnt) begin
         wait_cnt <= '0;
      end else if (wait_cnt != MAX_WAIT) begin
         wait_cnt <= wait_cnt + 4'd1;
      end
   end

   // Remember who gets the read data returning next cycle; writes own nothing.
   always_comb begin
      owner_d = OWN_NONE;
      if (cpu_gnt && !bus.cpu_we) begin
         owner_d = OWN_CPU_RD;
      end else if (dma_gnt && !bus.dma_we) begin
         owner_d = OWN_DMA_RD;
      end
   end

   // Owner state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // A response in flight when reset rises is dropped immediately, not one cycle later.
   assign cpu_rvalid     = (owner_q == OWN_CPU_RD) && !reset;
   assign dma_rvalid     = (owner_q == OWN_DMA_RD) && !reset;
   assign rd_data        = bus.mem_read_data;

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.dma_gnt    = dma_gnt;
   assign bus.cpu_rvalid = cpu_rvalid;
   assign bus.dma_rvalid = dma_rvalid;
   assign bus.cpu_rdata  = cpu_rvalid ? rd_data : '0;
   assign bus.dma_rdata  = dma_rvalid ? rd_data : '0;
   assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;

   // A waiting requester must hold its payload until granted.
   a_cpu_hold : assert property (@(posedge clock) disable iff (reset)
      (bus.cpu_req && !cpu_gnt) |=> $stable(cpu_cmd));
   a_dma_hold : assert property (@(posedge clock) disable iff (reset)
      (bus.dma_req && !dma_gnt) |=> $stable(dma_cmd));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a registered-read
// 128-word memory model and a reference arbitration/scoreboard model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int MAXW = 4;

   logic clock = 1'b0;
   logic reset;
   logic init_mem;

   dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

   dmem_arbiter #(
      .ADDR_W       (7),
      .DATA_W       (32),
      .DMA_MAX_WAIT (MAXW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // data_mem stand-in: write at the edge, registered read port
   logic [31:0] mem [128];
   logic [31:0] mem_rd;
   always @(posedge clock) begin
      if (init_mem) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'(i) + 32'd5;
         mem_rd <= '0;
      end else begin
         if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;
         if (bus.mem_read)  mem_rd <= mem[bus.mem_address];
      end
   end
   assign bus.mem_read_data = mem_rd;

   int nchk = 0;
   int nerr = 0;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] want);
      nchk++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic want);
      nchk++;
      assert (obs === want) else begin
         nerr++;
         $error("FAIL %s: observed %b expected %b", tag, obs, want);
      end
   endtask

   task automatic cpu_set(input logic r, input logic we, input logic [6:0] a, input logic [31:0] d);
      bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
   endtask

   task automatic dma_set(input logic r, input logic we, input logic [6:0] a, input logic [31:0] d);
      bus.dma_req = r; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // reference state for the random phase
   logic [31:0] ref_mem [128];
   logic        cp, dp, cwe, dwe;
   logic [6:0]  caddr, daddr;
   logic [31:0] cwd, dwd;
   logic        exp_cg, exp_dg, exp_cv, exp_dv, nxt_cv, nxt_dv, prev_cg;
   logic [31:0] exp_cd, exp_dd, nxt_cd, nxt_dd;
   int          wc;

   initial begin
      // ---- reset state ----
      reset = 1'b1; init_mem = 1'b1;
      cpu_set(1'b1, 1'b0, 7'd1, 32'd0);
      dma_set(1'b1, 1'b1, 7'd2, 32'd0);
      #1;
      chk1("rst_cpu_gnt", bus.cpu_gnt, 1'b0);
      chk1("rst_dma_gnt", bus.dma_gnt, 1'b0);
      chk1("rst_mem_read", bus.mem_read, 1'b0);
      chk1("rst_mem_write", bus.mem_write, 1'b0);
      tick(); tick();
      chk1("rst_cpu_rvalid", bus.cpu_rvalid, 1'b0);
      chk1("rst_dma_rvalid", bus.dma_rvalid, 1'b0);
      reset = 1'b0; init_mem = 1'b0;
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      dma_set(1'b0, 1'b0, 7'd0, 32'd0);
      tick();

      // ---- single CPU read ----
      cpu_set(1'b1, 1'b0, 7'd1, 32'd0);
      #1;
      chk1("t1_cpu_gnt", bus.cpu_gnt, 1'b1);
      chk1("t1_mem_read", bus.mem_read, 1'b1);
      chk32("t1_mem_addr", 32'(bus.mem_address), 32'd1);
      chk1("t1_stall", bus.cpu_stall, 1'b0);
      tick();
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t1_cpu_rvalid", bus.cpu_rvalid, 1'b1);
      chk32("t1_cpu_rdata", bus.cpu_rdata, 32'd6);
      chk1("t1_dma_rvalid", bus.dma_rvalid, 1'b0);
      tick();

      // ---- write then read-back in consecutive cycles ----
      cpu_set(1'b1, 1'b1, 7'd3, 32'hDEADBEEF);
      #1;
      chk1("t2_wr_gnt", bus.cpu_gnt, 1'b1);
      chk1("t2_mem_write", bus.mem_write, 1'b1);
      chk1("t2_mem_read", bus.mem_read, 1'b0);
      chk32("t2_wdata", bus.mem_write_data, 32'hDEADBEEF);
      tick();
      cpu_set(1'b1, 1'b0, 7'd3, 32'd0);
      #1;
      chk1("t2_rd_gnt", bus.cpu_gnt, 1'b1);
      chk1("t2_wr_no_rvalid", bus.cpu_rvalid, 1'b0);
      tick();
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t2_cpu_rvalid", bus.cpu_rvalid, 1'b1);
      chk32("t2_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
      tick();
      #1;
      chk1("t2_rvalid_drop", bus.cpu_rvalid, 1'b0);
      chk32("t2_rdata_gated", bus.cpu_rdata, 32'd0);

      // ---- simultaneous reads ----
      cpu_set(1'b1, 1'b0, 7'd0, 32'd0);
      dma_set(1'b1, 1'b0, 7'd2, 32'd0);
      #1;
      chk1("t3_cpu_gnt", bus.cpu_gnt, 1'b1);
      chk1("t3_dma_gnt0", bus.dma_gnt, 1'b0);
      chk1("t3_stall0", bus.cpu_stall, 1'b0);
      tick();
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t3_dma_gnt1", bus.dma_gnt, 1'b1);
      chk32("t3_dma_addr", 32'(bus.mem_address), 32'd2);
      chk1("t3_cpu_rvalid", bus.cpu_rvalid, 1'b1);
      chk32("t3_cpu_rdata", bus.cpu_rdata, 32'd5);
      chk1("t3_stall1", bus.cpu_stall, 1'b0);
      tick();
      dma_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t3_dma_rvalid", bus.dma_rvalid, 1'b1);
      chk32("t3_dma_rdata", bus.dma_rdata, 32'd7);
      chk1("t3_cpu_rvalid_off", bus.cpu_rvalid, 1'b0);
      tick();

      // ---- starvation: DMA wins after MAXW denials, counter then restarts ----
      prev_cg = 1'b0;
      for (int i = 0; i < 11; i++) begin
         cpu_set(1'b1, 1'b0, 7'd1, 32'd0);
         if (i <= 4)      dma_set(1'b1, 1'b1, 7'd10, 32'h1234);
         else if (i == 5) dma_set(1'b0, 1'b0, 7'd0, 32'd0);
         else             dma_set(1'b1, 1'b1, 7'd11, 32'h5678);
         exp_dg = (i == 4) || (i == 10);
         #1;
         chk1("t4_dma_gnt", bus.dma_gnt, exp_dg);
         chk1("t4_cpu_gnt", bus.cpu_gnt, !exp_dg);
         chk1("t4_stall", bus.cpu_stall, exp_dg);
         chk1("t4_mem_write", bus.mem_write, exp_dg);
         chk1("t4_cpu_rvalid", bus.cpu_rvalid, prev_cg);
         prev_cg = !exp_dg;
         tick();
      end
      dma_set(1'b0, 1'b0, 7'd0, 32'd0);
      cpu_set(1'b1, 1'b0, 7'd1, 32'd0);
      #1;
      chk1("t4_resume_gnt", bus.cpu_gnt, 1'b1);
      chk1("t4_after_dma_rvalid", bus.cpu_rvalid, 1'b0);
      tick();
      cpu_set(1'b1, 1'b0, 7'd10, 32'd0);
      #1;
      chk32("t4_rd1", bus.cpu_rdata, 32'd6);
      tick();
      cpu_set(1'b1, 1'b0, 7'd11, 32'd0);
      #1;
      chk32("t4_rd10", bus.cpu_rdata, 32'h1234);
      tick();
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk32("t4_rd11", bus.cpu_rdata, 32'h5678);
      tick();

      // ---- reset drops a pending DMA read ----
      dma_set(1'b1, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t5_dma_gnt", bus.dma_gnt, 1'b1);
      tick();
      reset = 1'b1;
      dma_set(1'b0, 1'b0, 7'd0, 32'd0);
      cpu_set(1'b1, 1'b1, 7'd5, 32'hFFFF);
      #1;
      chk1("t5_rvalid_in_rst", bus.dma_rvalid, 1'b0);
      chk32("t5_rdata_in_rst", bus.dma_rdata, 32'd0);
      chk1("t5_mem_read", bus.mem_read, 1'b0);
      chk1("t5_mem_write", bus.mem_write, 1'b0);
      chk1("t5_cpu_gnt", bus.cpu_gnt, 1'b0);
      tick();
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("t5_rvalid_in_rst2", bus.dma_rvalid, 1'b0);
      reset = 1'b0;
      tick();
      #1;
      chk1("t5_rvalid_after", bus.dma_rvalid, 1'b0);
      chk1("t5_cpu_rvalid_after", bus.cpu_rvalid, 1'b0);

      // ---- random traffic against scoreboard ----
      for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
      cp = 1'b0; dp = 1'b0; wc = 0;
      exp_cv = 1'b0; exp_dv = 1'b0; exp_cd = '0; exp_dd = '0;
      cwe = 1'b0; dwe = 1'b0; caddr = '0; daddr = '0; cwd = '0; dwd = '0;
      for (int n = 0; n < 1000; n++) begin
         if (!cp && ($urandom_range(0, 3) != 0)) begin
            cp = 1'b1; cwe = 1'($urandom_range(0, 1));
            caddr = 7'($urandom_range(0, 127)); cwd = $urandom();
         end
         if (!dp && ($urandom_range(0, 1) != 0)) begin
            dp = 1'b1; dwe = 1'($urandom_range(0, 1));
            daddr = 7'($urandom_range(0, 127)); dwd = $urandom();
         end
         cpu_set(cp, cwe, caddr, cwd);
         dma_set(dp, dwe, daddr, dwd);
         exp_dg = dp && ((wc == MAXW) || !cp);
         exp_cg = cp && !exp_dg;
         #1;
         chk1("rnd_one_gnt", bus.cpu_gnt & bus.dma_gnt, 1'b0);
         chk1("rnd_cpu_gnt", bus.cpu_gnt, exp_cg);
         chk1("rnd_dma_gnt", bus.dma_gnt, exp_dg);
         chk1("rnd_stall", bus.cpu_stall, cp && !exp_cg);
         chk1("rnd_cpu_rvalid", bus.cpu_rvalid, exp_cv);
         chk32("rnd_cpu_rdata", bus.cpu_rdata, exp_cv ? exp_cd : 32'd0);
         chk1("rnd_dma_rvalid", bus.dma_rvalid, exp_dv);
         chk32("rnd_dma_rdata", bus.dma_rdata, exp_dv ? exp_dd : 32'd0);
         nxt_cv = 1'b0; nxt_dv = 1'b0; nxt_cd = '0; nxt_dd = '0;
         if (exp_cg) begin
            if (cwe) ref_mem[caddr] = cwd;
            else begin nxt_cv = 1'b1; nxt_cd = ref_mem[caddr]; end
         end
         if (exp_dg) begin
            if (dwe) ref_mem[daddr] = dwd;
            else begin nxt_dv = 1'b1; nxt_dd = ref_mem[daddr]; end
         end
         if (!dp || exp_dg) wc = 0;
         else if (wc != MAXW) wc++;
         if (exp_cg) cp = 1'b0;
         if (exp_dg) dp = 1'b0;
         exp_cv = nxt_cv; exp_cd = nxt_cd;
         exp_dv = nxt_dv; exp_dd = nxt_dd;
         tick();
      end
      cpu_set(1'b0, 1'b0, 7'd0, 32'd0);
      dma_set(1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk1("rnd_last_cpu_rvalid", bus.cpu_rvalid, exp_cv);
      chk32("rnd_last_cpu_rdata", bus.cpu_rdata, exp_cv ? exp_cd : 32'd0);
      chk1("rnd_last_dma_rvalid", bus.dma_rvalid, exp_dv);
      chk32("rnd_last_dma_rdata", bus.dma_rdata, exp_dv ? exp_dd : 32'd0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
